// File: rtl/accel_dispatch_ctrl.sv
// accel_dispatch_ctrl: sequences blocking FFT / crypto accelerator ops.
// An op is accepted from ID, its operands and rd are captured, the
// selected engine gets a one-cycle start pulse, and its result is written
// back to the register file. Normal pipeline writeback has priority over
// this write. A WAIT watchdog flags engines that never answer.
module accel_dispatch_ctrl #(
  parameter int unsigned XLEN   = 19,
  parameter int unsigned RAW    = 3,
  parameter int unsigned TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_fft,
  input  logic            id_crypto,
  input  logic [4:0]      id_opcode,
  input  logic [RAW-1:0]  id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  output logic            id_kill,
  output logic            stall,
  output logic            fft_start,
  input  logic            fft_done,
  input  logic [XLEN-1:0] fft_result,
  output logic            cry_start,
  output logic            cry_mode,
  input  logic            cry_done,
  input  logic [XLEN-1:0] cry_result,
  output logic [XLEN-1:0] acc_op_a,
  output logic [XLEN-1:0] acc_op_b,
  input  logic            pipe_wb_valid,
  output logic            acc_wb_en,
  output logic [RAW-1:0]  acc_wb_addr,
  output logic [XLEN-1:0] acc_wb_data,
  output logic            acc_err,
  input  logic            err_clr
);

  localparam int unsigned CW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t            state_q, state_d;
  logic              kind_fft_q, kind_fft_d;
  logic              mode_q, mode_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [RAW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;

  logic              accept;
  logic              sel_done;
  logic [XLEN-1:0]   sel_result;
  logic              timeout;

  assign accept     = id_valid & (id_fft | id_crypto);
  assign sel_done   = kind_fft_q ? fft_done : cry_done;
  assign sel_result = kind_fft_q ? fft_result : cry_result;

  // Next-state, latch updates and handshake outputs; comb outputs are
  // forced low while reset is held so an in-flight op cannot write back.
  always_comb begin
    state_d    = state_q;
    kind_fft_d = kind_fft_q;
    mode_d     = mode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rd_d       = rd_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    timeout    = 1'b0;
    id_kill    = 1'b0;
    fft_start  = 1'b0;
    cry_start  = 1'b0;
    acc_wb_en  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        id_kill = accept & ~rst;
        if (accept) begin
          opa_d      = id_rs1_data;
          opb_d      = id_rs2_data;
          rd_d       = id_rd;
          kind_fft_d = id_fft;
          // Only 11010 (decrypt) sets the mode; 11001 and 11000 clear it.
          mode_d     = (id_opcode == 5'b11010);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fft_start = kind_fft_q & ~rst;
        cry_start = ~kind_fft_q & ~rst;
        cnt_d     = CW'(TO_CYC);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          res_d   = sel_result;
          state_d = S_WB;
        end else if (cnt_q == '0) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WB: begin
        acc_wb_en = ~pipe_wb_valid & ~rst;
        if (~pipe_wb_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d   = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
    stall_d = (state_d != S_IDLE);
  end

  // State, operand/result latches, watchdog counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_fft_q <= 1'b0;
      mode_q     <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_fft_q <= kind_fft_d;
      mode_q     <= mode_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
    end
  end

  assign stall       = stall_q;
  assign cry_mode    = mode_q;
  assign acc_op_a    = opa_q;
  assign acc_op_b    = opb_q;
  assign acc_wb_addr = rd_q;
  assign acc_wb_data = res_q;
  assign acc_err     = err_q;

endmodule

// File: tb/tb_accel_dispatch_ctrl.sv
// Bench for accel_dispatch_ctrl: directed vector table, hand-written
// corner sequences and randomized ops against a transaction-level model.
module tb_accel_dispatch_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_fft, id_crypto;
  logic [4:0]  id_opcode;
  logic [2:0]  id_rd;
  logic [18:0] id_rs1_data, id_rs2_data;
  logic        id_kill, stall, fft_start, fft_done, cry_start, cry_mode, cry_done;
  logic [18:0] fft_result, cry_result, acc_op_a, acc_op_b, acc_wb_data;
  logic        pipe_wb_valid, acc_wb_en, acc_err, err_clr;
  logic [2:0]  acc_wb_addr;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        err_m  = 1'b0;
  logic        hv = 1'b0, hf = 1'b0, hc = 1'b0;
  logic [4:0]  hop = 5'b0;

  accel_dispatch_ctrl #(.XLEN(19), .RAW(3), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_fft(id_fft), .id_crypto(id_crypto),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_kill(id_kill), .stall(stall), .fft_start(fft_start), .fft_done(fft_done),
    .fft_result(fft_result), .cry_start(cry_start), .cry_mode(cry_mode), .cry_done(cry_done),
    .cry_result(cry_result), .acc_op_a(acc_op_a), .acc_op_b(acc_op_b),
    .pipe_wb_valid(pipe_wb_valid), .acc_wb_en(acc_wb_en), .acc_wb_addr(acc_wb_addr),
    .acc_wb_data(acc_wb_data), .acc_err(acc_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic v, f, c; logic [4:0] op; logic [2:0] rd; logic [18:0] a, b;
    logic fd; logic [18:0] fr; logic cd; logic [18:0] cr; logic pw;
    logic kill, st, fs, cs, cm, we; logic [2:0] wa; logic [18:0] wd, oa, ob;
  } vec_t;

  function automatic vec_t mk(input logic v, f, c, input logic [4:0] op, input logic [2:0] rd,
                              input logic [18:0] a, b, input logic fd, input logic [18:0] fr,
                              input logic cd, input logic [18:0] cr, input logic pw,
                              input logic kill, st, fs, cs, cm, we, input logic [2:0] wa,
                              input logic [18:0] wd, oa, ob);
    vec_t x;
    x.v = v; x.f = f; x.c = c; x.op = op; x.rd = rd; x.a = a; x.b = b;
    x.fd = fd; x.fr = fr; x.cd = cd; x.cr = cr; x.pw = pw;
    x.kill = kill; x.st = st; x.fs = fs; x.cs = cs; x.cm = cm; x.we = we;
    x.wa = wa; x.wd = wd; x.oa = oa; x.ob = ob;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    id_valid = 0; id_fft = 0; id_crypto = 0; id_opcode = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; fft_done = 0; cry_done = 0;
    fft_result = '0; cry_result = '0; pipe_wb_valid = 0; err_clr = 0;
  endtask

  // One idle cycle with no accel op in ID; optional err_clr and late dones.
  task automatic idle_cycle(input bit clr, input bit v, input bit late);
    id_valid = v; id_fft = 0; id_crypto = 0; fft_done = late; cry_done = late;
    fft_result = 19'($urandom); cry_result = 19'($urandom); err_clr = clr;
    @(negedge clk);
    chk("idle_kill", id_kill, 0);
    chk("idle_stall", stall, 0);
    chk("idle_wb_en", acc_wb_en, 0);
    chk("idle_fft_start", fft_start, 0);
    chk("idle_cry_start", cry_start, 0);
    chk("idle_err", acc_err, err_m);
    if (clr) err_m = 1'b0;
    next_cycle();
    fft_done = 0; cry_done = 0; err_clr = 0;
  endtask

  // Whole op from acceptance to return to IDLE. The engine answers d cycles
  // after its start pulse; d > TO+1 means it never answers. nconf pipeline
  // writes collide with the writeback. Expected timeline: start at +1, WAIT
  // lasts up to TO+1 cycles, writeback commits on the first free WB cycle.
  task automatic run_op(input bit is_fft, input bit both, input logic [4:0] opc,
                        input logic [2:0] rd, input logic [18:0] a, b, res,
                        input int unsigned d, input int unsigned nconf,
                        input bit spur, input bit bclr);
    bit to, fin, wexp;
    int unsigned kd, last, conf;
    to = (d > TO + 1); kd = 1 + d; last = 2 + TO; conf = 0; fin = 0;
    id_valid = 1; id_fft = is_fft; id_crypto = !is_fft || both; id_opcode = opc;
    id_rd = rd; id_rs1_data = a; id_rs2_data = b;
    fft_done = 0; cry_done = 0; pipe_wb_valid = 0; err_clr = 0;
    @(negedge clk);
    chk("accept_kill", id_kill, 1);
    chk("accept_stall", stall, 0);
    chk("accept_err", acc_err, err_m);
    next_cycle();
    for (int unsigned k = 1; k < 64 && !fin; k++) begin
      id_valid = hv; id_fft = hf; id_crypto = hc; id_opcode = hop;
      id_rd = 3'($urandom); id_rs1_data = 19'($urandom); id_rs2_data = 19'($urandom);
      fft_done = (!to && k == kd && is_fft) ||
                 (spur && !is_fft && k >= 2 && k <= (to ? last : kd));
      cry_done = (!to && k == kd && !is_fft) ||
                 (spur && is_fft && k >= 2 && k <= (to ? last : kd));
      fft_result = is_fft ? res : 19'($urandom);
      cry_result = !is_fft ? res : 19'($urandom);
      pipe_wb_valid = !to && k > kd && conf < nconf;
      err_clr = bclr;
      wexp = !to && k > kd && !pipe_wb_valid;
      @(negedge clk);
      chk("busy_stall", stall, 1);
      chk("busy_kill", id_kill, 0);
      chk("fft_start", fft_start, (k == 1) && is_fft);
      chk("cry_start", cry_start, (k == 1) && !is_fft);
      chk("cry_mode", cry_mode, opc[1]);
      chk("acc_op_a", acc_op_a, a);
      chk("acc_op_b", acc_op_b, b);
      chk("acc_wb_en", acc_wb_en, wexp);
      if (wexp) begin
        chk("acc_wb_addr", acc_wb_addr, rd);
        chk("acc_wb_data", acc_wb_data, res);
      end
      chk("busy_err", acc_err, err_m);
      if (pipe_wb_valid) conf++;
      if (to && k == last) begin
        err_m = 1'b1;
        fin = 1;
      end else if (bclr) begin
        err_m = 1'b0;
      end
      if (wexp) fin = 1;
      next_cycle();
    end
    quiet_inputs();
  endtask

  vec_t tv[19];

  initial begin
    quiet_inputs();
    rst = 1;

    tv[0]  = mk(1,1,0,5'b11000,3'd3,19'h00012,19'h00034, 0,'0, 0,'0, 0, 1,0,0,0,0,0,'0,'0, 19'h0,19'h0);
    tv[1]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,1,0,0,0,'0,'0, 19'h00012,19'h00034);
    tv[2]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,0,0,0,0,'0,'0, 19'h00012,19'h00034);
    tv[3]  = mk(0,0,0,5'b0,'0,'0,'0, 1,19'h7ABCD, 0,'0, 0, 0,1,0,0,0,0,'0,'0, 19'h00012,19'h00034);
    tv[4]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,0,0,0,1,3'd3,19'h7ABCD, 19'h00012,19'h00034);
    tv[5]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,0,0,0,0,0,'0,'0, 19'h00012,19'h00034);
    tv[6]  = mk(1,0,1,5'b11010,3'd5,19'h55555,19'h2AAAA, 0,'0, 0,'0, 0, 1,0,0,0,0,0,'0,'0, 19'h00012,19'h00034);
    tv[7]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,0,1,1,0,'0,'0, 19'h55555,19'h2AAAA);
    tv[8]  = mk(0,0,0,5'b0,'0,'0,'0, 1,19'h11111, 0,'0, 0, 0,1,0,0,1,0,'0,'0, 19'h55555,19'h2AAAA);
    tv[9]  = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 1,19'h3C3C3, 0, 0,1,0,0,1,0,'0,'0, 19'h55555,19'h2AAAA);
    tv[10] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,0,0,1,1,3'd5,19'h3C3C3, 19'h55555,19'h2AAAA);
    tv[11] = mk(1,1,0,5'b11000,3'd6,19'h00001,19'h7FFFF, 0,'0, 0,'0, 0, 1,0,0,0,1,0,'0,'0, 19'h55555,19'h2AAAA);
    tv[12] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,1,0,0,0,'0,'0, 19'h00001,19'h7FFFF);
    tv[13] = mk(0,0,0,5'b0,'0,'0,'0, 1,19'h40001, 0,'0, 0, 0,1,0,0,0,0,'0,'0, 19'h00001,19'h7FFFF);
    tv[14] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 1, 0,1,0,0,0,0,'0,'0, 19'h00001,19'h7FFFF);
    tv[15] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 1, 0,1,0,0,0,0,'0,'0, 19'h00001,19'h7FFFF);
    tv[16] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 1, 0,1,0,0,0,0,'0,'0, 19'h00001,19'h7FFFF);
    tv[17] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,1,0,0,0,1,3'd6,19'h40001, 19'h00001,19'h7FFFF);
    tv[18] = mk(0,0,0,5'b0,'0,'0,'0, 0,'0, 0,'0, 0, 0,0,0,0,0,0,'0,'0, 19'h00001,19'h7FFFF);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_kill", id_kill, 0);   chk("rst_stall", stall, 0);
    chk("rst_fft_start", fft_start, 0); chk("rst_cry_start", cry_start, 0);
    chk("rst_cry_mode", cry_mode, 0);   chk("rst_wb_en", acc_wb_en, 0);
    chk("rst_wb_addr", acc_wb_addr, 0); chk("rst_wb_data", acc_wb_data, 0);
    chk("rst_op_a", acc_op_a, 0);   chk("rst_op_b", acc_op_b, 0);
    chk("rst_err", acc_err, 0);
    next_cycle();
    rst = 0;

    // Directed vectors: FFT op, crypto decrypt with spurious fft_done, WB conflict
    for (int i = 0; i < 19; i++) begin
      id_valid = tv[i].v; id_fft = tv[i].f; id_crypto = tv[i].c; id_opcode = tv[i].op;
      id_rd = tv[i].rd; id_rs1_data = tv[i].a; id_rs2_data = tv[i].b;
      fft_done = tv[i].fd; fft_result = tv[i].fr; cry_done = tv[i].cd; cry_result = tv[i].cr;
      pipe_wb_valid = tv[i].pw;
      @(negedge clk);
      chk($sformatf("v%0d_kill", i), id_kill, tv[i].kill);
      chk($sformatf("v%0d_stall", i), stall, tv[i].st);
      chk($sformatf("v%0d_fft_start", i), fft_start, tv[i].fs);
      chk($sformatf("v%0d_cry_start", i), cry_start, tv[i].cs);
      chk($sformatf("v%0d_cry_mode", i), cry_mode, tv[i].cm);
      chk($sformatf("v%0d_wb_en", i), acc_wb_en, tv[i].we);
      if (tv[i].we) begin
        chk($sformatf("v%0d_wb_addr", i), acc_wb_addr, tv[i].wa);
        chk($sformatf("v%0d_wb_data", i), acc_wb_data, tv[i].wd);
      end
      chk($sformatf("v%0d_op_a", i), acc_op_a, tv[i].oa);
      chk($sformatf("v%0d_op_b", i), acc_op_b, tv[i].ob);
      chk($sformatf("v%0d_err", i), acc_err, 0);
      next_cycle();
    end
    quiet_inputs();

    // Timeout, sticky error, err_clr, done in the last WAIT cycle
    run_op(1, 0, 5'b11000, 3'd1, 19'h0AAAA, 19'h05555, 19'h12345, TO + 2, 0, 0, 0);
    idle_cycle(0, 0, 0);
    idle_cycle(1, 0, 0);
    idle_cycle(0, 0, 0);
    run_op(0, 0, 5'b11001, 3'd7, 19'h11111, 19'h22222, 19'h33333, TO + 1, 0, 0, 0);
    idle_cycle(0, 0, 0);
    // Timeout while err_clr is held: set wins
    run_op(0, 0, 5'b11010, 3'd2, 19'h00F00, 19'h000F0, 19'h00000, TO + 2, 0, 0, 1);
    // rd = 0 written like any other register, both decode flags set -> FFT
    run_op(1, 1, 5'b11000, 3'd0, 19'h7FFFF, 19'h00000, 19'h7FFFF, 1, 1, 1, 0);

    // Reset in WAIT, late cry_done, then a normal crypto op
    id_valid = 1; id_crypto = 1; id_opcode = 5'b11010; id_rd = 3'd4;
    id_rs1_data = 19'h1234A; id_rs2_data = 19'h0BEEF;
    @(negedge clk); chk("r5_accept_kill", id_kill, 1);
    next_cycle();
    quiet_inputs();
    @(negedge clk); chk("r5_cry_start", cry_start, 1);
    next_cycle();
    rst = 1;
    @(negedge clk); chk("r5_wait_stall", stall, 1); chk("r5_wait_mode", cry_mode, 1);
    next_cycle();
    cry_done = 1; cry_result = 19'h5A5A5;
    @(negedge clk);
    chk("r5_stall", stall, 0);      chk("r5_wb_en", acc_wb_en, 0);
    chk("r5_err", acc_err, 0);      chk("r5_op_a", acc_op_a, 0);
    chk("r5_op_b", acc_op_b, 0);    chk("r5_mode", cry_mode, 0);
    chk("r5_wb_addr", acc_wb_addr, 0); chk("r5_wb_data", acc_wb_data, 0);
    chk("r5_fft_start", fft_start, 0); chk("r5_cry_start", cry_start, 0);
    next_cycle();
    rst = 0; err_m = 1'b0;
    @(negedge clk); chk("r5_late_wb_en", acc_wb_en, 0); chk("r5_late_stall", stall, 0);
    next_cycle();
    cry_done = 0;
    idle_cycle(0, 0, 0);
    run_op(0, 0, 5'b11001, 3'd4, 19'h0CAFE, 19'h0F00D, 19'h600DD, 2, 0, 0, 0);

    // Back-to-back: crypto op waits in ID under stall, accepted as it drops
    hv = 1; hf = 0; hc = 1; hop = 5'b11001;
    run_op(1, 0, 5'b11000, 3'd3, 19'h00101, 19'h00202, 19'h0ABCD, 2, 0, 0, 0);
    hv = 0; hc = 0; hop = '0;
    run_op(0, 0, 5'b11001, 3'd6, 19'h00303, 19'h00404, 19'h0DCBA, 1, 0, 0, 0);
    idle_cycle(0, 0, 0);

    // Randomized ops
    for (int n = 0; n < 150; n++) begin
      bit          f, bo;
      logic [4:0]  op;
      f  = 1'($urandom);
      bo = f && ($urandom_range(0, 3) == 0);
      op = f ? 5'b11000 : (($urandom_range(0, 1) == 1) ? 5'b11010 : 5'b11001);
      hv = 1'($urandom); hf = 1'($urandom); hc = 1'($urandom); hop = 5'($urandom);
      run_op(f, bo, op, 3'($urandom), 19'($urandom), 19'($urandom), 19'($urandom),
             $urandom_range(1, TO + 2), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 7) == 0);
      for (int unsigned j = $urandom_range(0, 2); j > 0; j--)
        idle_cycle($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
